prbs_pattern_checker: RTL
=========================

// Module: prbs_pattern_checker
// PURPOSE
// - Receive-side checker sitting directly downstream of the PRBS generator; consumes its 8-bit byte stream.
// - Locks on the 32-bit preamble pattern (MSB byte first) and counts consecutive full repetitions.
// - Flags lock once n back-to-back repetitions are seen; counts pattern violations; ignores LFSR payload after lock.
// PARAMETERS
// - ERR_W   8   width of saturating error counter err_count
// PORTS
// - CLK            in   1      system clock, rising edge
// - RSTn           in   1      asynchronous active-low reset
// - data_valid     in   1      frame enable; low = synchronous clear of all state except config
// - byte_valid     in   1      in_byte qualifier; checker samples only when data_valid & byte_valid
// - n              in   8      required repetitions; 0 means 256
// - pattern        in   32     expected preamble; byte order [31:24],[23:16],[15:8],[7:0]
// - in_byte        in   8      received byte from PRBS generator
// - pattern_found  out  1      sticky lock flag, high from FOUND entry until clear
// - found_pulse    out  1      one-cycle pulse on FOUND entry
// - rep_count      out  8      completed consecutive repetitions in current attempt (wraps 255->0 at n=0)
// - err_count      out  ERR_W  mismatches since last clear, saturates at all-ones
// - busy           out  1      high in MATCH state
// BEHAVIOUR
// - Reset (RSTn low, async): state=HUNT, idx=0, all outputs 0.
// - data_valid low (sync, highest priority after reset): state=HUNT, idx=0, all outputs 0 next edge.
// - No sample (byte_valid low, data_valid high): all state/outputs hold; found_pulse drops to 0.
// - All outputs registered; response visible the cycle after the sampling edge.
// - States: HUNT, MATCH, FOUND. idx (2 bit) = index of next expected byte in MATCH.
// - HUNT: in_byte==pattern[31:24] -> MATCH, idx=1, rep_count=0; else stay HUNT (no error counted).
// - MATCH, in_byte==pattern byte[idx]:
//   - idx<3: idx++.
//   - idx==3: if rep_count==n-1 (8-bit wrap, so n=0 -> 255): -> FOUND, pattern_found=1, found_pulse=1,
//     rep_count=rep_count+1 (mod 256); else rep_count++, idx=0.
// - MATCH, mismatch: err_count++ (saturating), rep_count=0; same-cycle re-hunt: if in_byte==pattern[31:24]
//   -> MATCH idx=1, else -> HUNT idx=0.
// - Mismatch at idx==0 (start of next repetition) is a mismatch like any other.
// - FOUND: terminal until data_valid low/reset; further bytes ignored; outputs frozen except found_pulse->0.
// - busy = (state==MATCH).
// - Config (n, pattern) must be stable while data_valid high; changes mid-frame give undefined lock.
// - Reset mid-frame: immediate return to reset values; no partial counts retained.
// TESTING
// - pattern=32'hDEADBEEF, n=2, stream DE AD BE EF DE AD BE EF -> found_pulse 1 cycle after 8th byte, rep_count=2, err_count=0.
// - Same cfg, stream DE AD 00 DE AD BE EF DE AD BE EF -> err_count=1 after 3rd byte, lock after 11th byte, rep_count=2.
// - Mismatch byte equal to DE (DE AD DE AD BE EF DE AD BE EF, n=2) -> err_count=1, re-hunt same cycle, lock after 10th byte.
// - n=0, 1024 correct bytes -> pattern_found only after 1024th byte, rep_count=0 (wrap); 1020 bytes -> still 0.
// - byte_valid toggling 1/0 every cycle over n=1 pattern -> lock after 4th valid byte, holds between samples.
// - Assert RSTn low mid-MATCH, then data_valid low after lock -> all outputs 0 immediately / next edge; 300 mismatches -> err_count=255.

Source files
------------

// File: rtl/prbs_pattern_checker.sv
// Preamble checker for the PRBS byte stream. It locks after n back-to-back
// repetitions of a 32-bit pattern and counts the mismatches seen while matching.
module prbs_pattern_checker #(
   parameter int ERR_W = 8
) (
   input  logic             CLK,
   input  logic             RSTn,
   input  logic             data_valid,
   input  logic             byte_valid,
   input  logic [7:0]       n,
   input  logic [31:0]      pattern,
   input  logic [7:0]       in_byte,
   output logic             pattern_found,
   output logic             found_pulse,
   output logic [7:0]       rep_count,
   output logic [ERR_W-1:0] err_count,
   output logic             busy
);

   typedef enum logic [1:0] {
      HUNT  = 2'd0,
      MATCH = 2'd1,
      FOUND = 2'd2
   } state_t;

   state_t      state;
   logic [1:0]  idx;
   logic [7:0]  exp_byte;
   logic [7:0]  last_rep;
   logic        first_hit;
   logic        sample;

   function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
      if (&v) sat_inc = v;
      else    sat_inc = v + {{(ERR_W-1){1'b0}}, 1'b1};
   endfunction

   function automatic logic [7:0] pat_byte(input logic [31:0] p, input logic [1:0] i);
      case (i)
         2'd0:    pat_byte = p[31:24];
         2'd1:    pat_byte = p[23:16];
         2'd2:    pat_byte = p[15:8];
         default: pat_byte = p[7:0];
      endcase
   endfunction

   // n==0 wraps to 255, so a full 256 repetitions are required
   assign last_rep  = n - 8'd1;
   assign exp_byte  = pat_byte(pattern, idx);
   assign first_hit = (in_byte == pattern[31:24]);
   assign sample    = data_valid & byte_valid;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         state         <= HUNT;
         idx           <= 2'd0;
         pattern_found <= 1'b0;
         found_pulse   <= 1'b0;
         rep_count     <= 8'd0;
         err_count     <= '0;
         busy          <= 1'b0;
      end else if (!data_valid) begin
         state         <= HUNT;
         idx           <= 2'd0;
         pattern_found <= 1'b0;
         found_pulse   <= 1'b0;
         rep_count     <= 8'd0;
         err_count     <= '0;
         busy          <= 1'b0;
      end else begin
         found_pulse <= 1'b0;
         if (sample) begin
            case (state)
               HUNT: begin
                  if (first_hit) begin
                     state     <= MATCH;
                     idx       <= 2'd1;
                     rep_count <= 8'd0;
                     busy      <= 1'b1;
                  end
               end
               MATCH: begin
                  if (in_byte == exp_byte) begin
                     if (idx != 2'd3) begin
                        idx <= idx + 2'd1;
                     end else if (rep_count == last_rep) begin
                        state         <= FOUND;
                        idx           <= 2'd0;
                        pattern_found <= 1'b1;
                        found_pulse   <= 1'b1;
                        rep_count     <= rep_count + 8'd1;
                        busy          <= 1'b0;
                     end else begin
                        rep_count <= rep_count + 8'd1;
                        idx       <= 2'd0;
                     end
                  end else begin
                     // a bad byte may itself start a fresh attempt
                     err_count <= sat_inc(err_count);
                     rep_count <= 8'd0;
                     if (first_hit) begin
                        state <= MATCH;
                        idx   <= 2'd1;
                        busy  <= 1'b1;
                     end else begin
                        state <= HUNT;
                        idx   <= 2'd0;
                        busy  <= 1'b0;
                     end
                  end
               end
               default: begin
               end
            endcase
         end
      end
   end

endmodule
